// File: rtl/gf180mcu_osu_sc_9t_cell2_tester_pkg.sv
// Shared types and constants for the 2-input cell tester.
// Latency: none (declarations only). Backpressure: not applicable.
// Optional macro GF180MCU_OSU_SC_CELL2_TESTER_SYNC_EN selects the Y synchroniser in the top.
package gf180mcu_osu_sc_cell2_tester_pkg;

   // Tester sequencing states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Four input combinations of a 2-input cell
   localparam int NUM_VECTORS = 4;
   // Depth of the optional Y synchroniser
   localparam int SYNC_STAGES = 2;
   // Settle counter width; holds S-1 for S up to 256
   localparam int CNT_W = 8;

   // Counter reload value for an effective settle time of s cycles
   function automatic logic [CNT_W-1:0] settle_reload(input int s);
      return CNT_W'(s - 1);
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_9t_cell2_tester_sync2.sv
// Two-flop synchroniser bringing the cell output Y into the CLK domain.
// Latency: 2 cycles from i_d to o_q. Backpressure: none, free-running.
// Synchronous active-high reset clears both flops to 0.
module gf180mcu_osu_sc_9T_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   // Two-stage capture of the asynchronous cell output
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/gf180mcu_osu_sc_9t_cell2_tester.sv
// Drives A1/A0 through 00,01,10,11, samples Y after a settle time and checks it against TRUTH.
// Latency: 4*(S+1) cycles from START edge to DONE; S = SETTLE_CYCLES (+2 with the synchroniser).
// Backpressure: START is only sampled in IDLE. Macro GF180MCU_OSU_SC_CELL2_TESTER_SYNC_EN adds the Y synchroniser.
module gf180mcu_osu_sc_9t_cell2_tester
   import gf180mcu_osu_sc_cell2_tester_pkg::*;
#(
   parameter int         SETTLE_CYCLES = 4,
   parameter logic [3:0] TRUTH         = 4'b0001
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic       Y,
   output logic       A0,
   output logic       A1,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS,
   output logic [2:0] ERRCNT,
   output logic [3:0] FAILMAP
);

   logic w_y;

`ifdef GF180MCU_OSU_SC_CELL2_TESTER_SYNC_EN
   // The synchroniser delay is folded into the settle time so the cell still
   // gets SETTLE_CYCLES of real settling before its response reaches the compare.
   // With the synchroniser, SETTLE_CYCLES must stay at or below 254 to fit the counter.
   localparam int S_EFF = SETTLE_CYCLES + SYNC_STAGES;

   gf180mcu_osu_sc_9T_sync2 u_sync (
      .i_clk (CLK),
      .i_rst (RST),
      .i_d   (Y),
      .o_q   (w_y)
   );
`else
   localparam int S_EFF = SETTLE_CYCLES;

   assign w_y = Y;
`endif

   localparam logic [CNT_W-1:0] RELOAD  = settle_reload(S_EFF);
   localparam logic [1:0]       LAST_V  = 2'(NUM_VECTORS - 1);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_v;
   logic             r_busy;
   logic             r_done;
   logic             r_pass;
   logic [2:0]       r_errcnt;
   logic [3:0]       r_failmap;

   state_t           w_state_nxt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic [1:0]       w_v_nxt;
   logic             w_busy_nxt;
   logic             w_done_nxt;
   logic             w_pass_nxt;
   logic [2:0]       w_errcnt_nxt;
   logic [3:0]       w_failmap_nxt;
   logic             w_mismatch;

   assign w_mismatch = (w_y != TRUTH[r_v]);

   // Next-state and next-output logic; every register holds unless a state acts on it
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_v_nxt       = r_v;
      w_busy_nxt    = r_busy;
      w_done_nxt    = 1'b0;
      w_pass_nxt    = r_pass;
      w_errcnt_nxt  = r_errcnt;
      w_failmap_nxt = r_failmap;

      case (r_state)
         ST_IDLE: begin
            if (START) begin
               w_v_nxt       = 2'd0;
               w_errcnt_nxt  = 3'd0;
               w_failmap_nxt = 4'd0;
               w_pass_nxt    = 1'b0;
               w_busy_nxt    = 1'b1;
               w_cnt_nxt     = RELOAD;
               w_state_nxt   = ST_SETTLE;
            end
         end

         ST_SETTLE: begin
            if (r_cnt == '0) begin
               w_state_nxt = ST_SAMPLE;
            end else begin
               w_cnt_nxt = r_cnt - 1'b1;
            end
         end

         ST_SAMPLE: begin
            if (w_mismatch) begin
               w_failmap_nxt[r_v] = 1'b1;
               w_errcnt_nxt       = r_errcnt + 3'd1;
            end
            if (r_v == LAST_V) begin
               // Verdict includes the vector being sampled on this same edge
               w_state_nxt = ST_DONE;
               w_done_nxt  = 1'b1;
               w_busy_nxt  = 1'b0;
               w_pass_nxt  = (w_failmap_nxt == 4'd0);
            end else begin
               w_v_nxt     = r_v + 2'd1;
               w_cnt_nxt   = RELOAD;
               w_state_nxt = ST_SETTLE;
            end
         end

         ST_DONE: begin
            // START is deliberately not looked at here
            w_state_nxt = ST_IDLE;
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // State, counter, vector and result registers with synchronous reset
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= ST_IDLE;
         r_cnt     <= '0;
         r_v       <= 2'd0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
         r_errcnt  <= 3'd0;
         r_failmap <= 4'd0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_v       <= w_v_nxt;
         r_busy    <= w_busy_nxt;
         r_done    <= w_done_nxt;
         r_pass    <= w_pass_nxt;
         r_errcnt  <= w_errcnt_nxt;
         r_failmap <= w_failmap_nxt;
      end
   end

   assign A0      = r_v[0];
   assign A1      = r_v[1];
   assign BUSY    = r_busy;
   assign DONE    = r_done;
   assign PASS    = r_pass;
   assign ERRCNT  = r_errcnt;
   assign FAILMAP = r_failmap;

endmodule
